// File: rtl/rf_pkg.sv
// Shared register-file types and sizes used by the writeback path.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_req_t;

  // x0 is hard-wired zero, so a write to it must never enable the port
  function automatic logic rf_writes_reg(input rf_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning from the
// priority pointer, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  int unsigned   idx;

  // Scan requesters starting at the pointer, wrapping modulo N; first hit wins
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!gnt_valid_o && req_i[idx]) begin
          gnt_valid_o    = 1'b1;
          gnt_o[idx]     = 1'b1;
          gnt_idx_o      = IW'(idx);
        end
      end
    end
  end

  // Next pointer: one past the winner, wrapping to 0 after the last requester
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      if (gnt_idx_o == IW'(N - 1)) ptr_d = '0;
      else                         ptr_d = gnt_idx_o + IW'(1);
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port among N_REQ writeback
// sources; the granted write is presented on rf_* one cycle later.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wb_stall,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_a3,
  output logic [DATA_W-1:0]       rf_wd3,
  output logic [ID_W-1:0]         grant_id
);

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              arb_en;

  logic              we_q,  we_d;
  logic [ADDR_W-1:0] a3_q,  a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic [ID_W-1:0]   gid_q, gid_d;

  // Unpack the flat request buses into per-requester lanes
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // No handshake completes while stalled or while held in reset
  assign arb_en = ~wb_stall & ~reset;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .en_i        (arb_en),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready = gnt;

  // Capture the winner's write; x0 writes are accepted but never enabled
  always_comb begin
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    gid_d = gid_q;
    if (gnt_valid) begin
      a3_d  = addr_arr[gnt_idx];
      wd3_d = data_arr[gnt_idx];
      gid_d = gnt_idx;
      we_d  = |addr_arr[gnt_idx];
    end
  end

  // Write-port output stage; reset discards any pending write at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      gid_q <= '0;
    end else begin
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      gid_q <= gid_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_a3    = a3_q;
  assign rf_wd3   = wd3_q;
  assign grant_id = gid_q;

endmodule
